// File: rtl/cipher_engine_seq.sv
// Iterative round-based encrypt/decrypt engine. One message in flight; the
// ciphertext carries the per-message nonce that was folded into the key.
module cipher_engine_seq #(
  parameter int DATA_W = 60,
  parameter int TAG_W  = 18,
  parameter int ROUNDS = 8,
  parameter int ROT    = 3
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mode,
  input  logic [DATA_W+TAG_W-1:0] in_data,
  input  logic [DATA_W-1:0]       key,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W+TAG_W-1:0] out_data,
  output logic                    out_mode,
  output logic                    busy
);

  localparam int RW       = $clog2(ROUNDS + 1);
  localparam int DEC_ROT0 = (ROUNDS - 1) % DATA_W;
  localparam logic [RW-1:0] LAST_RND = RW'(ROUNDS - 1);

  if (DATA_W < 2 || TAG_W < 1 || TAG_W > DATA_W || ROUNDS < 1 ||
      ROT < 1 || ROT > DATA_W - 1) begin : g_param_check
    $error("cipher_engine_seq: illegal DATA_W/TAG_W/ROUNDS/ROT");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x, input int amt);
    logic [2*DATA_W-1:0] w;
    w = {x, x} << (amt % DATA_W);
    return w[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int amt);
    logic [2*DATA_W-1:0] w;
    w = {x, x} >> (amt % DATA_W);
    return w[DATA_W-1:0];
  endfunction

  state_t                    r_state;
  logic [TAG_W-1:0]          r_nonce;
  logic [RW-1:0]             r_rnd;
  logic                      r_in_ready;
  logic                      r_busy;
  logic                      r_out_valid;
  logic [DATA_W+TAG_W-1:0]   r_out_data;
  logic                      r_out_mode;
  logic [DATA_W-1:0]         r_d;
  logic [DATA_W-1:0]         r_k;
  logic [TAG_W-1:0]          r_tag;
  logic                      r_mode;

  logic                      w_accept;
  logic [TAG_W-1:0]          w_tag;
  logic [DATA_W-1:0]         w_k0;
  logic [DATA_W-1:0]         w_d_next;

  always_comb begin
    w_accept = in_valid & r_in_ready;
    w_tag    = mode ? in_data[DATA_W+TAG_W-1:DATA_W] : r_nonce;
    // Tag is zero-extended, so only the low TAG_W key bits are perturbed.
    w_k0              = key;
    w_k0[TAG_W-1:0]   = key[TAG_W-1:0] ^ w_tag;
    w_d_next = r_mode ? (rotr(r_d, ROT) ^ r_k) : rotl(r_d ^ r_k, ROT);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_nonce     <= '0;
      r_rnd       <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_mode  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rnd      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
            if (!mode) r_nonce <= r_nonce + TAG_W'(1);
          end
        end
        S_RUN: begin
          r_rnd <= r_rnd + RW'(1);
          if (r_rnd == LAST_RND) begin
            r_out_data  <= {r_tag, w_d_next};
            r_out_mode  <= r_mode;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are only consumed after an accept.
  always_ff @(posedge Clk) begin
    if (r_state == S_IDLE && w_accept) begin
      r_mode <= mode;
      r_d    <= in_data[DATA_W-1:0];
      r_tag  <= w_tag;
      r_k    <= mode ? rotl(w_k0, DEC_ROT0) : w_k0;
    end else if (r_state == S_RUN) begin
      r_d <= w_d_next;
      r_k <= r_mode ? rotr(r_k, 1) : rotl(r_k, 1);
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_mode  = r_out_mode;

endmodule
